// File: rtl/cla16_pkg.sv
// Shared types and sizing for the nibble-serial 16-bit CLA add/subtract unit.
// Combinational definitions only; no state, no flow control.
package cla16_pkg;

   localparam int CLA_WIDTH  = 16;
   localparam int CLA_SLICE  = 4;
   localparam int CLA_NSLICE = CLA_WIDTH / CLA_SLICE;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Counter width for walking NS slices; never narrower than one bit.
   function automatic int cnt_width(input int ns);
      return (ns > 1) ? $clog2(ns) : 1;
   endfunction

endpackage

// File: rtl/cla_4bit.sv
// W-bit carry-lookahead slice: s = a + b + ci, also exposes the carry into the slice MSB.
// Purely combinational (zero latency), no handshake.
module cla_4bit
   import cla16_pkg::*;
#(
   parameter int W = CLA_SLICE
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o,
   output logic         c_msb_in_o
);

   logic [W-1:0] g;
   logic [W-1:0] p;
   logic [W:0]   c;
   logic         term;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Each carry is a flat sum of products of generate/propagate terms,
   // so no carry depends on another carry inside the slice.
   always_comb begin
      c    = '0;
      term = 1'b0;
      c[0] = ci_i;
      for (int i = 0; i < W; i++) begin
         term = ci_i;
         for (int k = 0; k <= i; k++) begin
            term = term & p[k];
         end
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & p[k];
            end
            c[i+1] = c[i+1] | term;
         end
      end
   end

   assign s_o        = p ^ c[W-1:0];
   assign co_o       = c[W];
   assign c_msb_in_o = c[W-1];

endmodule

// File: rtl/cla16_serial_addsub.sv
// WIDTH-bit add/subtract reusing one SLICE-bit CLA, LSB slice first; result valid WIDTH/SLICE cycles after accept.
// Backpressure: result held in RESP until out_ready_i; no new request accepted outside IDLE.
module cla16_serial_addsub
   import cla16_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int SLICE = CLA_SLICE
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             op_sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int NS    = WIDTH / SLICE;
   localparam int CNT_W = cnt_width(NS);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   int                 slice_base;
   logic               last_slice;
   logic [SLICE-1:0]   sl_a;
   logic [SLICE-1:0]   sl_b;
   logic [SLICE-1:0]   sl_s;
   logic               sl_co;
   logic               sl_cmsb;

   assign slice_base = int'(cnt_q) * SLICE;
   assign last_slice = (cnt_q == CNT_W'(NS - 1));
   assign sl_a       = opa_q[slice_base +: SLICE];
   assign sl_b       = opb_q[slice_base +: SLICE];

   cla_4bit #(
      .W (SLICE)
   ) u_slice (
      .a_i        (sl_a),
      .b_i        (sl_b),
      .ci_i       (carry_q),
      .s_o        (sl_s),
      .co_o       (sl_co),
      .c_msb_in_o (sl_cmsb)
   );

   always_comb begin
      state_d     = state_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               opa_d   = a_i;
               // Subtraction is A + ~B + cin; the inversion is folded in at capture.
               opb_d   = b_i ^ {WIDTH{op_sub_i}};
               carry_d = cin_i;
               cnt_d   = '0;
               state_d = CALC;
            end
         end

         CALC: begin
            sum_d[slice_base +: SLICE] = sl_s;
            carry_d                    = sl_co;
            cnt_d                      = cnt_q + 1'b1;
            if (last_slice) begin
               ovf_d   = sl_cmsb ^ sl_co;
               cnt_d   = '0;
               state_d = RESP;
            end
         end

         RESP: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // After the last slice the running carry register is the MSB carry-out.
   assign sum_o  = sum_q;
   assign cout_o = carry_q;
   assign ovf_o  = ovf_q;
   assign zero_o = (sum_q == '0);

endmodule

// File: doc/cla16_serial_addsub.md
# cla16_serial_addsub

Sequential 16-bit add/subtract unit that reuses one 4-bit carry-lookahead slice over four cycles, one nibble per cycle, LSB nibble first. It is the area-reduced, handshaked counterpart of the team's combinational 16-bit CLA. Operands come in over a valid/ready request channel. The result returns over a valid/ready response channel that supports back-pressure.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE
- SLICE, 4, bits processed per cycle (CLA slice width)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- cin  in  1  carry-in (add) / not-borrow-in (sub)
- op_sub  in  1  0 = A+B+cin; 1 = A+~B+cin (cin=1 gives A−B)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  out  1  sum == 0

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - in_ready=1.
  - Request accepted when in_valid & in_ready: latch A, latch B^{WIDTH{op_sub}}, latch cin into carry register, clear nibble counter.
  - Then go to CALC.
- CALC:
  - Each cycle, slice idx = counter.
  - The CLA slice adds opA[idx], opB[idx] and carry.
  - Write the slice sum into sum[idx], update carry.
  - On the last slice (idx = WIDTH/SLICE−1), also record ovf from the slice's internal carry into the MSB.
  - After the last slice, go to RESP.
- RESP:
  - out_valid=1. sum/cout/ovf/zero are stable until the response handshake.
  - On out_valid & out_ready, go to IDLE.
- in_ready is low in CALC and RESP. Requests presented there are ignored and not queued.
- Arithmetic is modulo 2^WIDTH. cout and ovf are independent flags. zero is computed from the registered sum.

## Timing
- Reset values (next edge with rst_n=0): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, zero=1, counter=0.
- Reset has priority over every handshake. Reset mid-CALC or mid-RESP aborts the operation and discards the result; no out_valid follows.
- Latency: request accepted at edge E. Slices complete at edges E+1..E+4. out_valid is high from after edge E+4.
- With out_ready held high, the response handshake occurs at edge E+5 and in_ready is high again after E+5. Peak throughput is one op per 6 cycles.
- out_ready low in RESP: hold indefinitely, outputs unchanged.
- out_ready is don't-care outside RESP.
- Operand inputs are sampled only at the accept edge. Later changes on A/B/cin/op_sub have no effect.

## Structure
- Package cla16_pkg holds:
  - the state enum (IDLE, CALC, RESP)
  - WIDTH/SLICE defaults
  - NSLICE = WIDTH/SLICE
- Sub-module cla_4bit: combinational SLICE-bit carry-lookahead adder (a, b, ci → s, co, c_msb_in). It is instantiated once.
- Top level holds the FSM, counter, operand/result registers, and flag logic.

## Test plan
- Add, no carry: A=0x0F0F, B=0xF0F0, cin=0, op_sub=0 → sum=0xFFFF, cout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept.
- Add, wrap: A=0xFFFF, B=0x000F, cin=0 → sum=0x000E, cout=1, ovf=0. Also A=0xFF00, B=0x00FF, cin=1 → sum=0x0000, cout=1, zero=1.
- Subtract:
  - A=0x0001, B=0x0002, cin=1, op_sub=1 → sum=0xFFFF, cout=0 (borrow).
  - A=0x1234, B=0x1234, cin=1, op_sub=1 → sum=0x0000, cout=1, zero=1.
- Signed overflow:
  - A=0x7FFF, B=0x0001, cin=0 add → sum=0x8000, ovf=1.
  - A=0x8000, B=0x0001, cin=1 sub → sum=0x7FFF, ovf=1.
- Back-pressure and ignored requests:
  - Hold out_ready=0 for 10 cycles in RESP → outputs and out_valid stable, in_ready=0.
  - A second request issued during CALC is not accepted.
  - The result matches only the first request.
- Reset mid-operation: assert rst_n=0 for one cycle at the 2nd CALC cycle → next cycle IDLE, in_ready=1, out_valid=0, sum=0, zero=1. A subsequent 0x0001+0x0001 yields 0x0002.
